// File: rtl/nametable_wr_arbiter_pkg.sv
// Shared definitions for the nametable write-port arbiter: FSM state
// encodings, table-select constants, bus widths and a saturating stat helper.
// Optional statistics outputs are enabled with NT_ARB_STATS_EN.
package nametable_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCROLL = 2'd1,
    S_CPU    = 2'd2,
    S_FORCE  = 2'd3
  } arb_state_t;

  localparam logic SEL_NAME = 1'b0;
  localparam logic SEL_ATTR = 1'b1;

  localparam int NT_ADDR_W = 9;
  localparam int NT_DATA_W = 32;
  localparam int NT_BE_W   = 4;

  // Saturating increment for 16-bit statistics counters
  function automatic logic [15:0] stat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/nametable_wr_arbiter_if.sv
// Bus bundle between the requesters (scroll engine, AHB write path) and the
// arbiter, plus the registered RAM write port. master = requester side,
// slave = arbiter side.
interface nametable_wr_arbiter_if
  import nametable_wr_arbiter_pkg::*;
#(
  parameter int ADDR_W = NT_ADDR_W,
  parameter int DATA_W = NT_DATA_W
);
  logic               scr_valid;
  logic               scr_ready;
  logic               scr_sel;
  logic [ADDR_W-1:0]  scr_addr;
  logic [DATA_W-1:0]  scr_data;
  logic [NT_BE_W-1:0] scr_be;

  logic               cpu_valid;
  logic               cpu_ready;
  logic               cpu_sel;
  logic [ADDR_W-1:0]  cpu_addr;
  logic [DATA_W-1:0]  cpu_data;
  logic [NT_BE_W-1:0] cpu_be;

  logic [NT_BE_W-1:0] ram_we;
  logic               ram_sel;
  logic [ADDR_W-1:0]  ram_addr;
  logic [DATA_W-1:0]  ram_wdata;
  logic               cpu_pending;

  modport master (
    output scr_valid, scr_sel, scr_addr, scr_data, scr_be,
    output cpu_valid, cpu_sel, cpu_addr, cpu_data, cpu_be,
    input  scr_ready, cpu_ready,
    input  ram_we, ram_sel, ram_addr, ram_wdata, cpu_pending
  );

  modport slave (
    input  scr_valid, scr_sel, scr_addr, scr_data, scr_be,
    input  cpu_valid, cpu_sel, cpu_addr, cpu_data, cpu_be,
    output scr_ready, cpu_ready,
    output ram_we, ram_sel, ram_addr, ram_wdata, cpu_pending
  );
endinterface

// File: rtl/nametable_wr_arbiter_fifo.sv
// nt_wr_fifo: small synchronous FIFO buffering CPU writes. The head entry is
// read combinationally so the arbiter can pop and register it in one cycle.
// A push while full is accepted only when a pop happens in the same cycle.
module nt_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 46
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_CNT);
  assign count   = count_reg;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr_reg];

  // Storage array: no reset, contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  // Pointers wrap modulo DEPTH; count tracks occupancy through push+pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/nametable_wr_arbiter.sv
// nametable_wr_arbiter: shares the nametable/attribute RAM write port between
// the scroll engine (priority, burst-locked) and buffered CPU writes, with a
// starvation counter forcing one CPU grant. Define NT_ARB_STATS_EN to add the
// stat_* counter outputs; arbitration is unaffected by it.
module nametable_wr_arbiter
  import nametable_wr_arbiter_pkg::*;
#(
  parameter int ADDR_W     = NT_ADDR_W,
  parameter int DATA_W     = NT_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  nametable_wr_arbiter_if.slave  bus
`ifdef NT_ARB_STATS_EN
  ,
  output logic [15:0]            stat_scr_cnt,
  output logic [15:0]            stat_cpu_cnt,
  output logic [15:0]            stat_force_cnt
`endif
);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int SW     = $clog2(STARVE_MAX + 1);
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W + NT_BE_W;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_PRE = SW'(STARVE_MAX - 1);

  arb_state_t         state_reg, state_next;
  logic [SW-1:0]      starve_reg, starve_next;
  logic               scr_ready, scr_fire;
  logic               cpu_ready, push;
  logic               pop, force_pop, more_cpu;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic               head_sel;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;
  logic [NT_BE_W-1:0] head_be;

  logic [NT_BE_W-1:0] ram_we_reg;
  logic               ram_sel_reg;
  logic [ADDR_W-1:0]  ram_addr_reg;
  logic [DATA_W-1:0]  ram_wdata_reg;

  nt_wr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({bus.cpu_sel, bus.cpu_addr, bus.cpu_data, bus.cpu_be}),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {head_sel, head_addr, head_data, head_be} = fifo_head;

  // A full FIFO still accepts when the head leaves in the same cycle
  assign cpu_ready = !fifo_full || pop;
  assign push      = bus.cpu_valid && cpu_ready;
  assign scr_fire  = bus.scr_valid && scr_ready;
  // Will the FIFO still hold something after this cycle's pop/push?
  assign more_cpu  = (fifo_count > CNT_W'(1)) || push;

  assign bus.scr_ready   = scr_ready;
  assign bus.cpu_ready   = cpu_ready;
  assign bus.cpu_pending = !fifo_empty;
  assign bus.ram_we      = ram_we_reg;
  assign bus.ram_sel     = ram_sel_reg;
  assign bus.ram_addr    = ram_addr_reg;
  assign bus.ram_wdata   = ram_wdata_reg;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and grant decode: at most one grant (scroll or pop) per cycle
  always_comb begin
    state_next = state_reg;
    scr_ready  = 1'b0;
    pop        = 1'b0;
    force_pop  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        scr_ready = 1'b1;
        if (bus.scr_valid) begin
          state_next = S_SCROLL;
        end else if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = more_cpu ? S_CPU : S_IDLE;
        end
      end
      S_SCROLL: begin
        if (!fifo_empty && starve_reg >= STARVE_LIM) begin
          state_next = S_FORCE;
        end else begin
          scr_ready = 1'b1;
          if (bus.scr_valid) begin
            // Counter saturates at the end of this cycle, so the next cycle is
            // the forced CPU slot; the scroll write here is still accepted.
            if (!fifo_empty && starve_reg == STARVE_PRE) state_next = S_FORCE;
          end else begin
            state_next = fifo_empty ? S_IDLE : S_CPU;
          end
        end
      end
      S_FORCE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          force_pop = 1'b1;
        end
        if (bus.scr_valid) state_next = S_SCROLL;
        else if (more_cpu) state_next = S_CPU;
        else               state_next = S_IDLE;
      end
      S_CPU: begin
        if (!fifo_empty) pop = 1'b1;
        if (bus.scr_valid) state_next = S_SCROLL;
        else if (more_cpu) state_next = S_CPU;
        else               state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Starvation counter: counts cycles a CPU write waits, clears on any pop
  always_comb begin
    starve_next = starve_reg;
    if (pop)                                       starve_next = '0;
    else if (!fifo_empty && starve_reg != STARVE_LIM) starve_next = starve_reg + 1'b1;
  end

  // Starvation counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_reg <= '0;
    else     starve_reg <= starve_next;
  end

  // Registered RAM write port; reset kills an in-flight write immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_we_reg    <= '0;
      ram_sel_reg   <= SEL_NAME;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
    end else if (scr_fire) begin
      ram_we_reg    <= bus.scr_be;
      ram_sel_reg   <= bus.scr_sel;
      ram_addr_reg  <= bus.scr_addr;
      ram_wdata_reg <= bus.scr_data;
    end else if (pop) begin
      ram_we_reg    <= head_be;
      ram_sel_reg   <= head_sel;
      ram_addr_reg  <= head_addr;
      ram_wdata_reg <= head_data;
    end else begin
      ram_we_reg    <= '0;
    end
  end

`ifdef NT_ARB_STATS_EN
  // Saturating counters of scroll accepts, CPU pops and forced grants
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_scr_cnt   <= '0;
      stat_cpu_cnt   <= '0;
      stat_force_cnt <= '0;
    end else begin
      if (scr_fire)  stat_scr_cnt   <= stat_inc(stat_scr_cnt);
      if (pop)       stat_cpu_cnt   <= stat_inc(stat_cpu_cnt);
      if (force_pop) stat_force_cnt <= stat_inc(stat_force_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_nametable_wr_arbiter.sv
// Directed bench for nametable_wr_arbiter with scroll/CPU scoreboards.
module tb_nametable_wr_arbiter;
  import nametable_wr_arbiter_pkg::*;

  localparam int STARVE_MAX = 16;

  typedef struct packed {
    logic        sel;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    wr_t w;
    int  cyc;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nametable_wr_arbiter_if bus ();

`ifdef NT_ARB_STATS_EN
  logic [15:0] stat_scr_cnt, stat_cpu_cnt, stat_force_cnt;
`endif

  nametable_wr_arbiter #(
    .ADDR_W(9), .DATA_W(32), .FIFO_DEPTH(4), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef NT_ARB_STATS_EN
    ,
    .stat_scr_cnt   (stat_scr_cnt),
    .stat_cpu_cnt   (stat_cpu_cnt),
    .stat_force_cnt (stat_force_cnt)
`endif
  );

  sb_t scr_sb[$];
  sb_t cpu_sb[$];
  wr_t cpu_q[$];
  int  cpu_arr[$];
  int  cpu_push_cyc[$];

  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  scr_left = 0;
  int  scr_stall = 0;
  int  cpu_stall = 0;
  int  n_scr_wr = 0;
  int  n_cpu_wr = 0;
  int  last_scr_cyc = 0;
  int  force_seen = 0;
  logic force_ready = 1'b0;
  logic after_force_ready = 1'b1;
  logic prev_force = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_cpu();
    if (cpu_q.size() > 0) begin
      bus.cpu_valid = 1'b1;
      {bus.cpu_sel, bus.cpu_addr, bus.cpu_data, bus.cpu_be} = cpu_q[0];
    end else begin
      bus.cpu_valid = 1'b0;
    end
  endtask

  task automatic start_scroll(input int n, input logic [8:0] addr);
    scr_left      = n;
    bus.scr_valid = 1'b1;
    bus.scr_sel   = SEL_NAME;
    bus.scr_addr  = addr;
    bus.scr_data  = 32'h5C00_0000 | {23'd0, addr};
    bus.scr_be    = 4'hF;
  endtask

  // One clock: check RAM output at negedge, capture handshakes, then advance
  task automatic cycle();
    wr_t o;
    sb_t e;
    sb_t t;
    logic scr_fire, cpu_fire;
    @(negedge clk);
    cyc++;
    if (bus.ram_we !== 4'h0) begin
      o.sel = bus.ram_sel; o.addr = bus.ram_addr; o.data = bus.ram_wdata; o.be = bus.ram_we;
      $display("cyc %0d ram write sel=%0d addr=%h data=%h we=%h", cyc, o.sel, o.addr, o.data, o.be);
      if (o.data[31:28] == 4'h5) begin
        n_scr_wr++;
        last_scr_cyc = cyc;
        if (scr_sb.size() == 0) check("scr_unexpected", 64'(o), 64'd0);
        else begin
          e = scr_sb.pop_front();
          check("scr_wr", 64'(o), 64'(e.w));
          check("scr_lat", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        n_cpu_wr++;
        cpu_arr.push_back(cyc);
        if (cpu_sb.size() == 0) check("cpu_unexpected", 64'(o), 64'd0);
        else begin
          e = cpu_sb.pop_front();
          check("cpu_wr", 64'(o), 64'(e.w));
        end
      end
    end
    if (prev_force) begin
      after_force_ready = bus.cpu_ready;
      prev_force = 1'b0;
    end
    if (bus.scr_valid && !bus.scr_ready) begin
      scr_stall++;
      if (force_seen == 0) begin
        force_ready = bus.cpu_ready;
        prev_force  = 1'b1;
      end
      force_seen++;
    end
    if (bus.cpu_valid && !bus.cpu_ready) cpu_stall++;
    scr_fire = bus.scr_valid && bus.scr_ready;
    cpu_fire = bus.cpu_valid && bus.cpu_ready;
    if (scr_fire && bus.scr_be != 4'h0) begin
      t.w = {bus.scr_sel, bus.scr_addr, bus.scr_data, bus.scr_be};
      t.cyc = cyc + 1;
      scr_sb.push_back(t);
    end
    if (cpu_fire) begin
      cpu_push_cyc.push_back(cyc);
      if (bus.cpu_be != 4'h0) begin
        t.w = {bus.cpu_sel, bus.cpu_addr, bus.cpu_data, bus.cpu_be};
        t.cyc = cyc;
        cpu_sb.push_back(t);
      end
    end
    @(posedge clk);
    #1;
    if (scr_fire) begin
      scr_left--;
      bus.scr_addr = bus.scr_addr + 9'd1;
      bus.scr_data = bus.scr_data + 32'd1;
      if (scr_left == 0) bus.scr_valid = 1'b0;
    end
    if (cpu_fire) begin
      void'(cpu_q.pop_front());
      load_cpu();
    end
  endtask

  function automatic logic busy();
    return bus.scr_valid || (cpu_q.size() != 0) || (scr_sb.size() != 0) ||
           (cpu_sb.size() != 0) || bus.cpu_pending;
  endfunction

  task automatic drain(input int max_cycles);
    int n = 0;
    while (busy() && n < max_cycles) begin
      cycle();
      n++;
    end
    check("drain_timeout", 64'(busy()), 64'd0);
    repeat (3) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int scr0, cpu0;
    bus.scr_valid = 1'b0; bus.scr_sel = 1'b0; bus.scr_addr = '0; bus.scr_data = '0; bus.scr_be = '0;
    bus.cpu_valid = 1'b0; bus.cpu_sel = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0; bus.cpu_be = '0;
    rst = 1'b1;
    repeat (2) cycle();
    check("rst_ram_we",      64'(bus.ram_we),      64'd0);
    check("rst_ram_sel",     64'(bus.ram_sel),     64'd0);
    check("rst_ram_addr",    64'(bus.ram_addr),    64'd0);
    check("rst_ram_wdata",   64'(bus.ram_wdata),   64'd0);
    check("rst_cpu_pending", 64'(bus.cpu_pending), 64'd0);
    check("rst_cpu_ready",   64'(bus.cpu_ready),   64'd1);
    check("rst_scr_ready",   64'(bus.scr_ready),   64'd1);
    rst = 1'b0;
    cycle();

    // CPU only: three attr writes plus one with be=0 (consumed, never written)
    cpu_arr.delete(); cpu_push_cyc.delete();
    for (int i = 0; i < 3; i++) cpu_q.push_back({SEL_ATTR, 9'h010, 32'hA5A5_0001 + 32'(i), 4'hF});
    cpu_q.push_back({SEL_NAME, 9'h020, 32'hA5A5_00FF, 4'h0});
    load_cpu();
    drain(60);
    check("t1_accepted",  64'(cpu_push_cyc.size()), 64'd4);
    check("t1_written",   64'(cpu_arr.size()), 64'd3);
    check("t1_back2back1", 64'(cpu_arr[1] - cpu_arr[0]), 64'd1);
    check("t1_back2back2", 64'(cpu_arr[2] - cpu_arr[0]), 64'd2);
    check("t1_latency",   64'((cpu_arr[0] - cpu_push_cyc[0]) <= 2), 64'd1);
    check("t1_pending",   64'(bus.cpu_pending), 64'd0);

    // Scroll only: 32-write burst, never stalled, one-cycle latency each
    scr_stall = 0; scr0 = n_scr_wr;
    start_scroll(32, 9'h000);
    drain(100);
    check("t2_no_stall", 64'(scr_stall), 64'd0);
    check("t2_count",    64'(n_scr_wr - scr0), 64'd32);

    // Starvation: one CPU write inside a long burst gets a single forced slot
    scr_stall = 0; scr0 = n_scr_wr; force_seen = 0;
    start_scroll(40, 9'h040);
    repeat (3) cycle();
    cpu_arr.delete(); cpu_push_cyc.delete();
    cpu_q.push_back({SEL_ATTR, 9'h1F0, 32'hC0DE_0003, 4'hF});
    load_cpu();
    drain(200);
    check("t3_one_stall", 64'(scr_stall), 64'd1);
    check("t3_cpu_count", 64'(cpu_arr.size()), 64'd1);
    check("t3_cpu_within", 64'((cpu_arr[0] - cpu_push_cyc[0]) <= STARVE_MAX + 2), 64'd1);
    check("t3_resumed",   64'(last_scr_cyc > cpu_arr[0]), 64'd1);
    check("t3_scr_count", 64'(n_scr_wr - scr0), 64'd40);

    // Backpressure and push+pop at full: six CPU writes during a long burst
    scr_stall = 0; cpu_stall = 0; force_seen = 0; cpu0 = n_cpu_wr;
    force_ready = 1'b0; after_force_ready = 1'b1;
    start_scroll(60, 9'h080);
    cycle();
    for (int i = 0; i < 6; i++) cpu_q.push_back({SEL_NAME, 9'h100 + 9'(i), 32'hC000_0010 + 32'(i), 4'hF});
    load_cpu();
    drain(400);
    check("t4_backpressure", 64'(cpu_stall > 0), 64'd1);
    check("t5_ready_at_force", 64'(force_ready), 64'd1);
    check("t5_full_after_force", 64'(after_force_ready), 64'd0);
    check("t4_cpu_count", 64'(n_cpu_wr - cpu0), 64'd6);

    // Reset mid-burst with two CPU writes pending
    start_scroll(100, 9'h0C0);
    cycle();
    cpu_q.push_back({SEL_ATTR, 9'h0AA, 32'hC0FF_0001, 4'hF});
    cpu_q.push_back({SEL_ATTR, 9'h0AB, 32'hC0FF_0002, 4'hF});
    load_cpu();
    repeat (4) cycle();
    check("t6_pre_pending", 64'(bus.cpu_pending), 64'd1);
    check("t6_pre_we",      64'(bus.ram_we), 64'hF);
    rst = 1'b1;
    #1;
    check("t6_we_cleared",  64'(bus.ram_we), 64'd0);
    check("t6_fifo_empty",  64'(bus.cpu_pending), 64'd0);
    check("t6_cpu_ready",   64'(bus.cpu_ready), 64'd1);
    check("t6_scr_ready",   64'(bus.scr_ready), 64'd1);
    bus.scr_valid = 1'b0; scr_left = 0;
    cpu_q.delete(); load_cpu();
    scr_sb.delete(); cpu_sb.delete();
    repeat (2) cycle();
    rst = 1'b0;
    scr0 = n_scr_wr; cpu0 = n_cpu_wr;
    repeat (10) cycle();
    check("t6_no_stale", 64'((n_scr_wr - scr0) + (n_cpu_wr - cpu0)), 64'd0);
    check("t6_idle_ready", 64'(bus.scr_ready), 64'd1);
    check("t6_idle_pending", 64'(bus.cpu_pending), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
